// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump and multi-cycle data memory.
// Optional build macro PERF_CNT_EN adds saturating StallCycles/FlushCount counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRd,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemRd,
  input  logic             MEM_MemWr,
  input  logic             Mem_Ready,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IFID_Flush,
  output logic             IDEX_En,
  output logic             IDEX_Flush,
  output logic             EXMEM_En,
  output logic             MEMWB_Bubble,
  output logic             Mem_Timeout,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
`endif
  output logic             Busy
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       timeout_q, timeout_d;

  logic mem_acc;
  logic at_limit;
  logic mem_stall;
  logic load_use;

  assign mem_acc   = MEM_MemRd | MEM_MemWr;
  assign at_limit  = (state_q == WAIT) && (wcnt_q == WCNT_LAST);
  assign mem_stall = mem_acc & ~Mem_Ready & ~at_limit;
  assign load_use  = EX_MemRd && (EX_Rd != 5'd0) &&
                     ((ID_UsesRs && (ID_Rs == EX_Rd)) || (ID_UsesRt && (ID_Rt == EX_Rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      wcnt_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_acc && !Mem_Ready) begin
          state_d = WAIT;
          wcnt_d  = 8'd0;
        end
      end
      WAIT: begin
        if (Mem_Ready) begin
          state_d = RUN;
        end else if (wcnt_q == WCNT_LAST) begin
          // Abandon the access; the pipeline retires it as if memory had answered.
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    PC_En        = 1'b1;
    IFID_En      = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_En      = 1'b1;
    IDEX_Flush   = 1'b0;
    EXMEM_En     = 1'b1;
    MEMWB_Bubble = 1'b0;
    Busy         = (state_q == WAIT);
    if (reset) begin
      PC_En    = 1'b0;
      IFID_En  = 1'b0;
      IDEX_En  = 1'b0;
      EXMEM_En = 1'b0;
      Busy     = 1'b0;
    end else if (mem_stall) begin
      PC_En        = 1'b0;
      IFID_En      = 1'b0;
      IDEX_En      = 1'b0;
      EXMEM_En     = 1'b0;
      MEMWB_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      // The ID instruction is wrong-path, so any load-use or jump it raises is moot.
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (load_use) begin
      PC_En      = 1'b0;
      IFID_En    = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (ID_Jump) begin
      IFID_Flush = 1'b1;
    end
  end

  assign Mem_Timeout = timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_evt, flush_evt;

  assign stall_evt = !reset && (mem_stall || (load_use && !EX_BranchTaken));
  assign flush_evt = IFID_Flush | IDEX_Flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with MEM_TIMEOUT=4 so timeout windows stay short.
// Control outputs are packed as {PC_En,IFID_En,IFID_Flush,IDEX_En,IDEX_Flush,EXMEM_En,MEMWB_Bubble,Busy}.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  localparam logic [7:0] C_ZERO    = 8'b0000_0000;
  localparam logic [7:0] C_DEF     = 8'b1101_0100;
  localparam logic [7:0] C_LU      = 8'b0001_1100;
  localparam logic [7:0] C_BR      = 8'b1111_1100;
  localparam logic [7:0] C_JMP     = 8'b1111_0100;
  localparam logic [7:0] C_STALL   = 8'b0000_0010;
  localparam logic [7:0] C_STALL_W = 8'b0000_0011;
  localparam logic [7:0] C_WAIT_OK = 8'b1101_0101;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd;
  logic       ID_UsesRs, ID_UsesRt, ID_Jump, EX_MemRd, EX_BranchTaken;
  logic       MEM_MemRd, MEM_MemWr, Mem_Ready;
  logic       PC_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush, EXMEM_En;
  logic       MEMWB_Bubble, Mem_Timeout, Busy;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] StallCycles, FlushCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRd(EX_MemRd), .EX_Rd(EX_Rd),
    .EX_BranchTaken(EX_BranchTaken), .MEM_MemRd(MEM_MemRd), .MEM_MemWr(MEM_MemWr),
    .Mem_Ready(Mem_Ready), .PC_En(PC_En), .IFID_En(IFID_En), .IFID_Flush(IFID_Flush),
    .IDEX_En(IDEX_En), .IDEX_Flush(IDEX_Flush), .EXMEM_En(EXMEM_En),
    .MEMWB_Bubble(MEMWB_Bubble), .Mem_Timeout(Mem_Timeout),
`ifdef PERF_CNT_EN
    .StallCycles(StallCycles), .FlushCount(FlushCount),
`endif
    .Busy(Busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {PC_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush, EXMEM_En, MEMWB_Bubble, Busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRd = 1'b0; EX_Rd = 5'd0; EX_BranchTaken = 1'b0;
    MEM_MemRd = 1'b0; MEM_MemWr = 1'b0; Mem_Ready = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic jmp);
    ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt; ID_Jump = jmp;
  endtask

  task automatic set_ex(input logic ld, input logic [4:0] rd, input logic br);
    EX_MemRd = ld; EX_Rd = rd; EX_BranchTaken = br;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    check("reset_comb_ctl", 32'(ctl()), 32'(C_ZERO));
    next_cycle();
    check("reset_ctl", 32'(ctl()), 32'(C_ZERO));
    check("reset_timeout", 32'(Mem_Timeout), 32'd0);
`ifdef PERF_CNT_EN
    check("reset_stallcnt", 32'(StallCycles), 32'd0);
    check("reset_flushcnt", 32'(FlushCount), 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("default_ctl", 32'(ctl()), 32'(C_DEF));

    // load-use and register-0 exemption
    set_id(5'd8, 1'b1, 5'd3, 1'b1, 1'b0); set_ex(1'b1, 5'd8, 1'b0); #1;
    check("lu_rs", 32'(ctl()), 32'(C_LU));
    next_cycle();
    set_ex(1'b0, 5'd8, 1'b0); #1;
    check("lu_released", 32'(ctl()), 32'(C_DEF));
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b0); set_ex(1'b1, 5'd0, 1'b0); #1;
    check("lu_r0", 32'(ctl()), 32'(C_DEF));
    set_id(5'd9, 1'b0, 5'd4, 1'b1, 1'b0); set_ex(1'b1, 5'd9, 1'b0); #1;
    check("lu_rs_unused", 32'(ctl()), 32'(C_DEF));
    set_id(5'd2, 1'b1, 5'd9, 1'b1, 1'b0); #1;
    check("lu_rt", 32'(ctl()), 32'(C_LU));

    // branch / jump priority
    set_ex(1'b1, 5'd9, 1'b1); #1;
    check("br_over_lu", 32'(ctl()), 32'(C_BR));
    set_id(5'd2, 1'b1, 5'd9, 1'b1, 1'b1); set_ex(1'b1, 5'd9, 1'b0); #1;
    check("lu_over_jump", 32'(ctl()), 32'(C_LU));
    set_id(5'd1, 1'b0, 5'd1, 1'b0, 1'b1); set_ex(1'b0, 5'd0, 1'b0); #1;
    check("jump_only", 32'(ctl()), 32'(C_JMP));
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();

    // memory wait: ready low 3 cycles, then high
    MEM_MemRd = 1'b1; Mem_Ready = 1'b0; #1;
    check("mw_run_stall", 32'(ctl()), 32'(C_STALL));
    next_cycle();
    check("mw_wait0", 32'(ctl()), 32'(C_STALL_W));
    next_cycle();
    check("mw_wait1", 32'(ctl()), 32'(C_STALL_W));
    next_cycle();
    Mem_Ready = 1'b1; #1;
    check("mw_ready", 32'(ctl()), 32'(C_WAIT_OK));
    next_cycle();
    MEM_MemRd = 1'b0; Mem_Ready = 1'b0; #1;
    check("mw_back_run", 32'(ctl()), 32'(C_DEF));
    check("mw_no_timeout", 32'(Mem_Timeout), 32'd0);

    // zero-wait store
    MEM_MemWr = 1'b1; Mem_Ready = 1'b1; #1;
    check("zw_comb", 32'(ctl()), 32'(C_DEF));
    next_cycle();
    check("zw_state", 32'(ctl()), 32'(C_DEF));
    MEM_MemWr = 1'b0; Mem_Ready = 1'b0;
    next_cycle();

    // timeout with MEM_TIMEOUT=4, plus stall-over-branch priority
    MEM_MemRd = 1'b1; #1;
    check("to_run_stall", 32'(ctl()), 32'(C_STALL));
    next_cycle();
    check("to_wcnt0", 32'(ctl()), 32'(C_STALL_W));
    next_cycle();
    EX_BranchTaken = 1'b1; #1;
    check("to_wcnt1_br", 32'(ctl()), 32'(C_STALL_W));
    next_cycle();
    EX_BranchTaken = 1'b0; #1;
    check("to_wcnt2", 32'(ctl()), 32'(C_STALL_W));
    check("to_no_pulse_yet", 32'(Mem_Timeout), 32'd0);
    next_cycle();
    check("to_release", 32'(ctl()), 32'(C_WAIT_OK));
    check("to_release_pulse", 32'(Mem_Timeout), 32'd0);
    next_cycle();
    MEM_MemRd = 1'b0; #1;
    check("to_pulse", 32'(Mem_Timeout), 32'd1);
    check("to_after_ctl", 32'(ctl()), 32'(C_DEF));
    next_cycle();
    check("to_pulse_end", 32'(Mem_Timeout), 32'd0);

    // reset while waiting at wcnt=2
    MEM_MemRd = 1'b1; #1;
    next_cycle();
    next_cycle();
    next_cycle();
    check("rw_wcnt2", 32'(ctl()), 32'(C_STALL_W));
    reset = 1'b1; #1;
    check("rw_forced", 32'(ctl()), 32'(C_ZERO));
    next_cycle();
    check("rw_ctl", 32'(ctl()), 32'(C_ZERO));
    check("rw_timeout", 32'(Mem_Timeout), 32'd0);
`ifdef PERF_CNT_EN
    check("rw_stallcnt", 32'(StallCycles), 32'd0);
    check("rw_flushcnt", 32'(FlushCount), 32'd0);
`endif
    next_cycle();
    check("rw_hold_timeout", 32'(Mem_Timeout), 32'd0);
    MEM_MemRd = 1'b0; reset = 1'b0; #1;
    check("rw_run", 32'(ctl()), 32'(C_DEF));
    next_cycle();
    check("rw_no_pulse", 32'(Mem_Timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
